// File: rtl/line_buffer_ring_pkg.sv
// line_buffer_ring_pkg: shared video line-buffer constants and pointer/count width helpers
package line_buffer_ring_pkg;
  localparam int LB_DW   = 16;
  localparam int LB_AW   = 6;
  localparam int LB_NBUF = 2;
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/line_buffer_ring_ram.sv
// line_ram: one line bank, single write port and registered read port, contents survive reset
module line_ram import line_buffer_ring_pkg::*; #(
  parameter int DW = LB_DW,
  parameter int AW = LB_AW
) (
  input  logic          CLK_I,
  input  logic          we,
  input  logic [AW-1:0] w_adr,
  input  logic [DW-1:0] w_dat,
  input  logic [AW-1:0] r_adr,
  output logic [DW-1:0] r_dat
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge CLK_I) begin
    if (we) mem[w_adr] <= w_dat;
    r_dat <= mem[r_adr];
  end
endmodule

// File: rtl/line_buffer_ring.sv
// line_buffer_ring: ring of NBUF line banks between a line fetcher (store side) and the CRTC (display side)
module line_buffer_ring import line_buffer_ring_pkg::*; #(
  parameter int DW     = LB_DW,
  parameter int AW     = LB_AW,
  parameter int NBUF   = LB_NBUF,
  parameter int REPEAT = 1
) (
  input  logic                     CLK_I,
  input  logic                     RST_I,
  input  logic                     LINE_I,
  input  logic [AW-1:0]            F_ADR_I,
  output logic [DW-1:0]            F_DAT_O,
  input  logic [AW-1:0]            S_ADR_I,
  input  logic [DW-1:0]            S_DAT_I,
  input  logic                     S_WE_I,
  input  logic                     S_DONE_I,
  output logic                     S_RDY_O,
  output logic                     UNDERRUN_O,
  output logic [cnt_w(NBUF)-1:0]   PEND_O
);
  localparam int PW = ptr_w(NBUF);
  localparam int CW = cnt_w(NBUF);
  logic [PW-1:0] rd_ptr, wr_ptr, rd_nxt, sel_q;
  logic [CW-1:0] pend;
  logic          disp_valid, dv_nxt, valid_q, commit, consume, empty;
  logic [DW-1:0] r_dat [NBUF];
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (int'(p) == NBUF - 1) ? '0 : p + 1'b1;
  endfunction
  // wr_ptr always sits pend+disp_valid banks ahead of rd_ptr, so this keeps the store bank off the displayed one
  assign S_RDY_O = int'(pend) + int'(disp_valid) < NBUF;
  assign empty   = pend == '0;
  assign commit  = S_DONE_I && S_RDY_O;
  assign consume = LINE_I && !empty;
  always_comb begin
    rd_nxt = (LINE_I && disp_valid && (!empty || REPEAT == 0)) ? inc(rd_ptr) : rd_ptr;
    dv_nxt = LINE_I ? (!empty || (REPEAT != 0 && disp_valid)) : disp_valid;
  end
  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      pend       <= '0;
      disp_valid <= 1'b0;
      UNDERRUN_O <= 1'b0;
      sel_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      rd_ptr     <= rd_nxt;
      disp_valid <= dv_nxt;
      wr_ptr     <= commit ? inc(wr_ptr) : wr_ptr;
      pend       <= pend + CW'(commit) - CW'(consume);
      UNDERRUN_O <= LINE_I && empty;
      sel_q      <= rd_ptr;
      valid_q    <= disp_valid;
    end
  end
  for (genvar i = 0; i < NBUF; i++) begin : g_bank
    line_ram #(.DW(DW), .AW(AW)) u_bank (
      .CLK_I(CLK_I),
      .we   (RST_I && S_WE_I && S_RDY_O && wr_ptr == PW'(i)),
      .w_adr(S_ADR_I),
      .w_dat(S_DAT_I),
      .r_adr(F_ADR_I),
      .r_dat(r_dat[i])
    );
  end
  // bank data and bank select are both registered, so this mux yields the one-cycle fetch latency
  assign F_DAT_O = valid_q ? r_dat[sel_q] : '0;
  assign PEND_O  = pend;
endmodule

// File: tb/tb_line_buffer_ring.sv
// tb_line_buffer_ring: three configurations driven in lockstep, checked against a line-serial reference model
module tb_line_buffer_ring;
  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b0, LINE_I = 1'b0, S_WE_I = 1'b0, S_DONE_I = 1'b0;
  logic [5:0]  F_ADR_I = '0, S_ADR_I = '0;
  logic [15:0] S_DAT_I = '0;
  logic [15:0] f_dat [3];
  logic        s_rdy [3], und [3];
  logic [1:0]  pend0, pend1;
  logic [2:0]  pend2;
  int n_chk = 0, n_fail = 0;
  always #5 CLK_I = ~CLK_I;

  line_buffer_ring #(.NBUF(2), .REPEAT(1)) u0 (.CLK_I(CLK_I), .RST_I(RST_I), .LINE_I(LINE_I), .F_ADR_I(F_ADR_I),
    .F_DAT_O(f_dat[0]), .S_ADR_I(S_ADR_I), .S_DAT_I(S_DAT_I), .S_WE_I(S_WE_I), .S_DONE_I(S_DONE_I),
    .S_RDY_O(s_rdy[0]), .UNDERRUN_O(und[0]), .PEND_O(pend0));
  line_buffer_ring #(.NBUF(2), .REPEAT(0)) u1 (.CLK_I(CLK_I), .RST_I(RST_I), .LINE_I(LINE_I), .F_ADR_I(F_ADR_I),
    .F_DAT_O(f_dat[1]), .S_ADR_I(S_ADR_I), .S_DAT_I(S_DAT_I), .S_WE_I(S_WE_I), .S_DONE_I(S_DONE_I),
    .S_RDY_O(s_rdy[1]), .UNDERRUN_O(und[1]), .PEND_O(pend1));
  line_buffer_ring #(.NBUF(4), .REPEAT(1)) u2 (.CLK_I(CLK_I), .RST_I(RST_I), .LINE_I(LINE_I), .F_ADR_I(F_ADR_I),
    .F_DAT_O(f_dat[2]), .S_ADR_I(S_ADR_I), .S_DAT_I(S_DAT_I), .S_WE_I(S_WE_I), .S_DONE_I(S_DONE_I),
    .S_RDY_O(s_rdy[2]), .UNDERRUN_O(und[2]), .PEND_O(pend2));

  // Model: lines get serial numbers; serial n lives in bank n % NBUF.
  // ns = lines committed, nc = lines taken for display, dv = something is on screen.
  int          nb  [3] = '{2, 2, 4};
  bit          rep [3] = '{1'b1, 1'b0, 1'b1};
  int          ns [3], nc [3];
  bit          dv [3];
  logic [15:0] mem   [3][4][64];
  bit          known [3][4][64];
  logic [15:0] ef [3];
  bit          ek [3], eu [3];

  typedef struct {
    bit          line;
    logic [5:0]  fadr;
    logic [15:0] f;
    bit          u;
    int          p;
  } vec_t;
  vec_t tbl [8];

  function automatic logic [31:0] dpend(input int k);
    return k == 0 ? 32'(pend0) : k == 1 ? 32'(pend1) : 32'(pend2);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input bit rst, input bit line, input bit we, input bit done,
                      input logic [5:0] fa, input logic [5:0] sa, input logic [15:0] sd);
    @(negedge CLK_I);
    RST_I = rst; LINE_I = line; S_WE_I = we; S_DONE_I = done;
    F_ADR_I = fa; S_ADR_I = sa; S_DAT_I = sd;
    for (int k = 0; k < 3; k++) begin
      int p, db;
      bit rdy;
      if (!rst) begin
        ns[k] = 0; nc[k] = 0; dv[k] = 1'b0;
        ef[k] = 16'h0; ek[k] = 1'b1; eu[k] = 1'b0;
      end else begin
        p   = ns[k] - nc[k];
        rdy = p + int'(dv[k]) < nb[k];
        db  = dv[k] ? (nc[k] - 1) % nb[k] : 0;
        ef[k] = dv[k] ? mem[k][db][fa] : 16'h0;
        ek[k] = !dv[k] || known[k][db][fa];
        eu[k] = line && p == 0;
        if (we && rdy) begin
          mem[k][ns[k] % nb[k]][sa]   = sd;
          known[k][ns[k] % nb[k]][sa] = 1'b1;
        end
        if (line && p > 0) begin
          nc[k]++;
          dv[k] = 1'b1;
        end else if (line && !rep[k]) dv[k] = 1'b0;
        if (done && rdy) ns[k]++;
      end
    end
    @(posedge CLK_I);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (ek[k]) chk($sformatf("u%0d_fdat", k), 32'(f_dat[k]), 32'(ef[k]));
      chk($sformatf("u%0d_underrun", k), 32'(und[k]), 32'(eu[k]));
      chk($sformatf("u%0d_pend", k), dpend(k), 32'(ns[k] - nc[k]));
      chk($sformatf("u%0d_rdy", k), 32'(s_rdy[k]), 32'((ns[k] - nc[k]) + int'(dv[k]) < nb[k]));
    end
  endtask

  task automatic store_line(input logic [15:0] base);
    for (int a = 0; a < 64; a++) step(1, 0, 1, 0, 6'd0, 6'(a), base + 16'(a));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 6'd0, 16'h2000, 1'b0, 2};
    tbl[1] = '{1'b0, 6'd9, 16'h3009, 1'b0, 2};
    tbl[2] = '{1'b1, 6'd9, 16'h3009, 1'b0, 1};
    tbl[3] = '{1'b0, 6'd9, 16'h4009, 1'b0, 1};
    tbl[4] = '{1'b1, 6'd1, 16'h4001, 1'b0, 0};
    tbl[5] = '{1'b0, 6'd9, 16'h5009, 1'b0, 0};
    tbl[6] = '{1'b1, 6'd9, 16'h5009, 1'b1, 0};
    tbl[7] = '{1'b0, 6'd9, 16'h5009, 1'b0, 0};

    repeat (2) step(0, 0, 0, 0, 6'd7, 6'd0, 16'h0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_fdat_u%0d", k), 32'(f_dat[k]), 32'h0);
      chk($sformatf("reset_rdy_u%0d", k), 32'(s_rdy[k]), 32'h1);
      chk($sformatf("reset_pend_u%0d", k), dpend(k), 32'h0);
      chk($sformatf("reset_underrun_u%0d", k), 32'(und[k]), 32'h0);
    end
    step(1, 0, 0, 0, 6'd33, 6'd0, 16'h0);
    chk("idle_fetch33", 32'(f_dat[0]), 32'h0);

    store_line(16'h1000);
    step(1, 0, 0, 1, 6'd0, 6'd0, 16'h0);
    chk("line1_pend1", dpend(0), 32'h1);
    step(1, 1, 0, 0, 6'd0, 6'd0, 16'h0);
    chk("line1_pend0", dpend(0), 32'h0);
    step(1, 0, 0, 0, 6'd5, 6'd0, 16'h0);
    chk("line1_fetch5", 32'(f_dat[0]), 32'h1005);

    store_line(16'h2000);
    step(1, 0, 0, 1, 6'd0, 6'd0, 16'h0);
    chk("full_rdy_u0", 32'(s_rdy[0]), 32'h0);
    chk("full_pend_u0", dpend(0), 32'h1);
    chk("nbuf4_rdy_u2", 32'(s_rdy[2]), 32'h1);
    step(1, 0, 1, 0, 6'd0, 6'd0, 16'hDEAD);
    step(1, 1, 0, 0, 6'd0, 6'd0, 16'h0);
    chk("line2_rdy_u0", 32'(s_rdy[0]), 32'h1);
    step(1, 0, 0, 0, 6'd0, 6'd0, 16'h0);
    chk("line2_fetch0_u0", 32'(f_dat[0]), 32'h2000);

    step(1, 1, 0, 0, 6'd0, 6'd0, 16'h0);
    for (int k = 0; k < 3; k++) chk($sformatf("underrun_pulse_u%0d", k), 32'(und[k]), 32'h1);
    step(1, 0, 0, 0, 6'd3, 6'd0, 16'h0);
    chk("underrun_clear_u0", 32'(und[0]), 32'h0);
    chk("repeat_fetch_u0", 32'(f_dat[0]), 32'h2003);
    chk("blank_fetch_u1", 32'(f_dat[1]), 32'h0);
    chk("repeat_fetch_u2", 32'(f_dat[2]), 32'h2003);

    for (int l = 0; l < 3; l++) begin
      store_line(16'h3000 + 16'(l) * 16'h1000);
      step(1, 0, 0, 1, 6'd0, 6'd0, 16'h0);
    end
    chk("nbuf4_pend3", dpend(2), 32'h3);
    chk("nbuf4_full_rdy", 32'(s_rdy[2]), 32'h0);
    for (int i = 0; i < 8; i++) begin
      step(1, tbl[i].line, 0, 0, tbl[i].fadr, 6'd0, 16'h0);
      chk($sformatf("tbl%0d_fdat", i), 32'(f_dat[2]), 32'(tbl[i].f));
      chk($sformatf("tbl%0d_underrun", i), 32'(und[2]), 32'(tbl[i].u));
      chk($sformatf("tbl%0d_pend", i), dpend(2), 32'(tbl[i].p));
      chk($sformatf("tbl%0d_rdy", i), 32'(s_rdy[2]), 32'h1);
    end

    step(0, 0, 0, 0, 6'd0, 6'd0, 16'h0);
    store_line(16'h6000);
    step(1, 0, 0, 1, 6'd0, 6'd0, 16'h0);
    chk("same_cycle_pre_pend", dpend(0), 32'h1);
    step(1, 1, 0, 1, 6'd0, 6'd0, 16'h0);
    chk("same_cycle_pend_u0", dpend(0), 32'h1);
    chk("same_cycle_pend_u2", dpend(2), 32'h1);
    step(1, 0, 0, 0, 6'd7, 6'd0, 16'h0);
    chk("same_cycle_fetch7", 32'(f_dat[0]), 32'h6007);

    for (int a = 0; a < 10; a++) step(1, 0, 1, 0, 6'd0, 6'(a), 16'h7000 + 16'(a));
    step(0, 1, 1, 1, 6'd7, 6'd3, 16'hBEEF);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("midreset_fdat_u%0d", k), 32'(f_dat[k]), 32'h0);
      chk($sformatf("midreset_underrun_u%0d", k), 32'(und[k]), 32'h0);
      chk($sformatf("midreset_pend_u%0d", k), dpend(k), 32'h0);
      chk($sformatf("midreset_rdy_u%0d", k), 32'(s_rdy[k]), 32'h1);
    end
    step(1, 1, 0, 0, 6'd7, 6'd0, 16'h0);
    chk("postreset_underrun", 32'(und[0]), 32'h1);
    step(1, 0, 0, 0, 6'd7, 6'd0, 16'h0);
    chk("postreset_blank", 32'(f_dat[0]), 32'h0);

    for (int i = 0; i < 3000; i++) begin
      bit r, l, w, d;
      r = $urandom_range(0, 299) != 0;
      l = $urandom_range(0, 15) == 0;
      w = $urandom_range(0, 1) == 1;
      d = $urandom_range(0, 11) == 0;
      step(r, l, w, d, 6'($urandom), 6'($urandom), 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
